// File: rtl/computation_control_hd_param.sv
`default_nettype none
// =============================================================================
// Module   : computation_control_hd_param
// Brief    : Control FSM for the digit-serial multiplier: x/y digit intake,
//            CA_RAM write/read-back sequencing and result handshake.
//            Optional op_count counter is built when PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
// =============================================================================
module computation_control_hd_param #(
  parameter int RAM_ADDR_WIDTH = 7,
  parameter int DIGIT_W        = 2,
  parameter int CNT_LSB        = 2,
  parameter int MAX_CYCLE      = (2**RAM_ADDR_WIDTH) - 1
) (
  input  logic                              clk,
  input  logic                              asyn_reset,
  input  logic [RAM_ADDR_WIDTH+CNT_LSB-1:0] cnt_master,
  input  logic [DIGIT_W-1:0]                x_value,
  input  logic                              data_x_vld,
  output logic                              data_x_rdy,
  input  logic [DIGIT_W-1:0]                y_value,
  input  logic                              data_y_vld,
  output logic                              data_y_rdy,
  input  logic [DIGIT_W-1:0]                p_value_in,
  output logic [DIGIT_W-1:0]                p_value,
  output logic                              data_out_vld,
  input  logic                              data_out_rdy,
  output logic [DIGIT_W-1:0]                x_value_reg,
  output logic [DIGIT_W-1:0]                y_value_reg,
  output logic [RAM_ADDR_WIDTH-1:0]         rd_addr,
  output logic [RAM_ADDR_WIDTH-1:0]         rd_addr_res,
  output logic [RAM_ADDR_WIDTH-1:0]         wr_addr_res,
  output logic                              write_enable,
  output logic                              enable_all,
  output logic                              enable_cnt,
  output logic                              enable_V_reg,
  output logic [1:0]                        carry_out_control,
  output logic                              enable_shift,
  output logic                              enable_shift_upper,
  output logic                              fix_next_state,
  output logic [2:0]                        STATE,
  output logic                              overflow,
  output logic [15:0]                       op_count
);

  localparam int                        c_cnt_w    = RAM_ADDR_WIDTH + CNT_LSB;
  localparam logic [RAM_ADDR_WIDTH-1:0] c_max      = RAM_ADDR_WIDTH'(MAX_CYCLE);
  localparam logic [RAM_ADDR_WIDTH-1:0] c_addr_one = RAM_ADDR_WIDTH'(1);
  localparam logic [RAM_ADDR_WIDTH-1:0] c_addr_zero = '0;

  typedef enum logic [2:0] {
    ST_START     = 3'd0,
    ST_WRITE_IN  = 3'd1,
    ST_READ_OUT  = 3'd2,
    ST_READ_LAST = 3'd3,
    ST_END       = 3'd4
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        r_hd_x;
  logic                        r_hd_y;
  logic [RAM_ADDR_WIDTH-1:0]   r_cc;
  logic [RAM_ADDR_WIDTH-1:0]   r_rd_addr_res;
  logic [RAM_ADDR_WIDTH-1:0]   r_wr_addr_res;
  logic [DIGIT_W-1:0]          r_x_reg;
  logic [DIGIT_W-1:0]          r_y_reg;
  logic [DIGIT_W-1:0]          r_p;
  logic                        r_enable_shift;
  logic                        r_fix;
  logic                        r_overflow;

  logic [RAM_ADDR_WIDTH-1:0]   w_cycle_num;
  logic                        w_sat;
  logic [RAM_ADDR_WIDTH-1:0]   w_n;
  logic                        w_x_fire;
  logic                        w_y_fire;
  logic                        w_start_go;
  logic                        w_out_fire;
  logic                        w_x_rdy;
  logic                        w_y_rdy;
  logic                        w_out_vld;
  logic                        w_we;
  logic                        w_en_all;
  logic                        w_en_cnt;
  logic                        w_en_v;
  logic [1:0]                  w_carry;
  logic                        w_shift_upper;
  logic [RAM_ADDR_WIDTH-1:0]   w_rd_addr;
  logic                        w_unused_cnt_lsb;

  // Low counter bits only sequence digits inside the datapath.
  assign w_unused_cnt_lsb = ^cnt_master[CNT_LSB-1:0];

  assign w_cycle_num = cnt_master[c_cnt_w-1:CNT_LSB];
  assign w_sat       = (w_cycle_num > c_max);
  assign w_n         = w_sat ? c_max : w_cycle_num;
  assign w_out_fire  = (r_state == ST_END) && data_out_rdy;

  always_comb begin
    w_state_nxt   = r_state;
    w_x_fire      = 1'b0;
    w_y_fire      = 1'b0;
    w_start_go    = 1'b0;
    w_x_rdy       = 1'b0;
    w_y_rdy       = 1'b0;
    w_out_vld     = 1'b0;
    w_we          = 1'b0;
    w_en_all      = 1'b0;
    w_en_cnt      = 1'b0;
    w_en_v        = 1'b0;
    w_carry       = 2'd0;
    w_shift_upper = 1'b0;
    w_rd_addr     = r_cc;
    case (r_state)
      ST_START: begin
        w_x_rdy    = !r_hd_x;
        w_y_rdy    = !r_hd_y;
        w_x_fire   = data_x_vld && !r_hd_x;
        w_y_fire   = data_y_vld && !r_hd_y;
        // A digit arriving this cycle counts, so the last handshake starts the pass.
        w_start_go = (r_hd_x || w_x_fire) && (r_hd_y || w_y_fire);
        if (w_start_go) begin
          w_state_nxt = ST_WRITE_IN;
          w_rd_addr   = w_n;
        end
      end
      ST_WRITE_IN: begin
        w_we        = 1'b1;
        w_en_all    = 1'b1;
        w_en_cnt    = 1'b1;
        w_en_v      = 1'b1;
        w_state_nxt = (r_cc == c_addr_zero) ? ST_READ_LAST : ST_READ_OUT;
      end
      ST_READ_OUT: begin
        w_en_all = 1'b1;
        w_carry  = 2'd1;
        if (r_cc == c_addr_zero) begin
          w_state_nxt = ST_READ_LAST;
        end
      end
      ST_READ_LAST: begin
        w_en_all      = 1'b1;
        w_carry       = 2'd2;
        w_shift_upper = 1'b1;
        w_state_nxt   = ST_END;
      end
      ST_END: begin
        w_out_vld = 1'b1;
        if (w_out_fire) begin
          w_state_nxt = ST_START;
        end
      end
      default: begin
        w_state_nxt = ST_START;
      end
    endcase
    if (asyn_reset) begin
      w_x_rdy       = 1'b0;
      w_y_rdy       = 1'b0;
      w_out_vld     = 1'b0;
      w_we          = 1'b0;
      w_en_all      = 1'b0;
      w_en_cnt      = 1'b0;
      w_en_v        = 1'b0;
      w_carry       = 2'd0;
      w_shift_upper = 1'b0;
      w_rd_addr     = c_addr_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      r_state        <= ST_START;
      r_hd_x         <= 1'b0;
      r_hd_y         <= 1'b0;
      r_cc           <= c_addr_zero;
      r_rd_addr_res  <= c_addr_zero;
      r_wr_addr_res  <= c_addr_zero;
      r_x_reg        <= '0;
      r_y_reg        <= '0;
      r_p            <= '0;
      r_enable_shift <= 1'b0;
      r_fix          <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fix   <= (r_state == ST_WRITE_IN);
      case (r_state)
        ST_START: begin
          if (w_x_fire) begin
            r_x_reg <= x_value;
            r_hd_x  <= 1'b1;
          end
          if (w_y_fire) begin
            r_y_reg <= y_value;
            r_hd_y  <= 1'b1;
          end
          if (w_start_go) begin
            r_hd_x        <= 1'b0;
            r_hd_y        <= 1'b0;
            r_cc          <= w_n;
            r_rd_addr_res <= w_n;
            r_wr_addr_res <= w_n;
            if (w_sat) begin
              r_overflow <= 1'b1;
            end
          end
        end
        ST_WRITE_IN: begin
          if (r_cc == c_addr_zero) begin
            r_enable_shift <= 1'b0;
          end else begin
            r_cc           <= r_cc - c_addr_one;
            r_rd_addr_res  <= r_cc - c_addr_one;
            r_wr_addr_res  <= r_cc;
            r_enable_shift <= 1'b1;
          end
        end
        ST_READ_OUT: begin
          if (r_cc != c_addr_zero) begin
            r_cc          <= r_cc - c_addr_one;
            r_rd_addr_res <= r_rd_addr_res - c_addr_one;
            r_wr_addr_res <= r_wr_addr_res - c_addr_one;
          end else begin
            r_rd_addr_res  <= c_addr_zero;
            r_wr_addr_res  <= c_addr_zero;
            r_enable_shift <= 1'b0;
          end
        end
        ST_READ_LAST: begin
          r_p           <= p_value_in;
          r_rd_addr_res <= c_addr_zero;
          r_wr_addr_res <= c_addr_zero;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [15:0] r_op_count;

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      r_op_count <= 16'd0;
    end else if (w_out_fire) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  assign op_count = r_op_count;
`else
  assign op_count = 16'd0;
`endif

  assign STATE              = asyn_reset ? 3'd0 : r_state;
  assign data_x_rdy         = w_x_rdy;
  assign data_y_rdy         = w_y_rdy;
  assign data_out_vld       = w_out_vld;
  assign write_enable       = w_we;
  assign enable_all         = w_en_all;
  assign enable_cnt         = w_en_cnt;
  assign enable_V_reg       = w_en_v;
  assign carry_out_control  = w_carry;
  assign enable_shift_upper = w_shift_upper;
  assign rd_addr            = w_rd_addr;
  assign rd_addr_res        = r_rd_addr_res;
  assign wr_addr_res        = r_wr_addr_res;
  assign x_value_reg        = r_x_reg;
  assign y_value_reg        = r_y_reg;
  assign p_value            = r_p;
  assign enable_shift       = r_enable_shift;
  assign fix_next_state     = r_fix;
  assign overflow           = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_computation_control_hd_param.sv
`default_nettype none
// =============================================================================
// Module   : tb_computation_control_hd_param
// Brief    : Randomised self-checking bench; expectations come from a
//            per-pass timeline model (n, latency, address countdown).
// Revision : 1.0 - initial release
// =============================================================================
module tb_computation_control_hd_param;

  localparam int AW   = 7;
  localparam int DW   = 2;
  localparam int CL   = 2;
  localparam int MAXC = 100;

  logic              clk;
  logic              asyn_reset;
  logic [AW+CL-1:0]  cnt_master;
  logic [DW-1:0]     x_value;
  logic              data_x_vld;
  logic              data_x_rdy;
  logic [DW-1:0]     y_value;
  logic              data_y_vld;
  logic              data_y_rdy;
  logic [DW-1:0]     p_value_in;
  logic [DW-1:0]     p_value;
  logic              data_out_vld;
  logic              data_out_rdy;
  logic [DW-1:0]     x_value_reg;
  logic [DW-1:0]     y_value_reg;
  logic [AW-1:0]     rd_addr;
  logic [AW-1:0]     rd_addr_res;
  logic [AW-1:0]     wr_addr_res;
  logic              write_enable;
  logic              enable_all;
  logic              enable_cnt;
  logic              enable_V_reg;
  logic [1:0]        carry_out_control;
  logic              enable_shift;
  logic              enable_shift_upper;
  logic              fix_next_state;
  logic [2:0]        STATE;
  logic              overflow;
  logic [15:0]       op_count;

  computation_control_hd_param #(
    .RAM_ADDR_WIDTH(AW),
    .DIGIT_W       (DW),
    .CNT_LSB       (CL),
    .MAX_CYCLE     (MAXC)
  ) dut (
    .clk               (clk),
    .asyn_reset        (asyn_reset),
    .cnt_master        (cnt_master),
    .x_value           (x_value),
    .data_x_vld        (data_x_vld),
    .data_x_rdy        (data_x_rdy),
    .y_value           (y_value),
    .data_y_vld        (data_y_vld),
    .data_y_rdy        (data_y_rdy),
    .p_value_in        (p_value_in),
    .p_value           (p_value),
    .data_out_vld      (data_out_vld),
    .data_out_rdy      (data_out_rdy),
    .x_value_reg       (x_value_reg),
    .y_value_reg       (y_value_reg),
    .rd_addr           (rd_addr),
    .rd_addr_res       (rd_addr_res),
    .wr_addr_res       (wr_addr_res),
    .write_enable      (write_enable),
    .enable_all        (enable_all),
    .enable_cnt        (enable_cnt),
    .enable_V_reg      (enable_V_reg),
    .carry_out_control (carry_out_control),
    .enable_shift      (enable_shift),
    .enable_shift_upper(enable_shift_upper),
    .fix_next_state    (fix_next_state),
    .STATE             (STATE),
    .overflow          (overflow),
    .op_count          (op_count)
  );

  int            n_pass;
  int            n_total;
  logic          m_ovf;
  logic [15:0]   m_ops;
  logic [DW-1:0] m_xreg;
  logic [DW-1:0] m_yreg;
  logic [DW-1:0] m_p;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Control outputs packed for compact comparison against an expected vector.
  function automatic logic [36:0] snap();
    return {STATE, carry_out_control, write_enable, enable_all, enable_cnt, enable_V_reg,
            enable_shift, enable_shift_upper, fix_next_state, data_out_vld,
            data_x_rdy, data_y_rdy, rd_addr, rd_addr_res, wr_addr_res, overflow};
  endfunction

  function automatic logic [15:0] exp_ops();
`ifdef PERF_CNT_EN
    return m_ops;
`else
    return 16'd0;
`endif
  endfunction

  task automatic model_reset();
    m_ovf  = 1'b0;
    m_ops  = 16'd0;
    m_xreg = '0;
    m_yreg = '0;
    m_p    = '0;
  endtask

  // One full transaction: x at cycle xd, y at cycle yd, cycle_num cyc,
  // result held off for `hold` cycles in END. Every cycle is checked.
  task automatic run_pass(input int xd, input int yd, input int cyc, input int hold, input string tag);
    int            n;
    int            last;
    logic [DW-1:0] xv;
    logic [DW-1:0] yv;
    logic [36:0]   want;
    n    = (cyc > MAXC) ? MAXC : cyc;
    last = (xd > yd) ? xd : yd;
    xv   = DW'($urandom);
    yv   = DW'($urandom);
    cnt_master = {AW'(cyc), CL'($urandom)};
    for (int t = 0; t <= last; t++) begin
      data_x_vld = (t == xd);
      data_y_vld = (t == yd);
      x_value    = (t == xd) ? xv : DW'($urandom);
      y_value    = (t == yd) ? yv : DW'($urandom);
      p_value_in = DW'($urandom);
      @(negedge clk);
      want = {3'd0, 2'd0, 4'd0, 3'd0, 1'b0, (t <= xd), (t <= yd),
              (t == last) ? AW'(n) : AW'(0), AW'(0), AW'(0), m_ovf};
      n_total++;
      if (snap() !== want) $display("FAIL %s start t=%0d got %h exp %h", tag, t, snap(), want);
      else n_pass++;
      n_total++;
      if ({x_value_reg, y_value_reg} !== {m_xreg, m_yreg})
        $display("FAIL %s capture t=%0d got %h exp %h", tag, t, {x_value_reg, y_value_reg}, {m_xreg, m_yreg});
      else n_pass++;
      if (t == xd) m_xreg = xv;
      if (t == yd) m_yreg = yv;
      @(posedge clk); #1;
    end
    data_x_vld = 1'b0;
    data_y_vld = 1'b0;
    if (cyc > MAXC) m_ovf = 1'b1;
    // Timeline after go: WRITE_IN, n x READ_OUT, READ_LAST.
    for (int k = 0; k <= n + 1; k++) begin
      p_value_in = DW'($urandom);
      x_value    = DW'($urandom);
      y_value    = DW'($urandom);
      @(negedge clk);
      if (k == 0)
        want = {3'd1, 2'd0, 4'b1111, 3'b000, 1'b0, 2'b00, AW'(n), AW'(n), AW'(n), m_ovf};
      else if (k <= n)
        want = {3'd2, 2'd1, 4'b0100, 1'b1, 1'b0, (k == 1), 1'b0, 2'b00,
                AW'(n - k), AW'(n - k), AW'(n - k + 1), m_ovf};
      else begin
        want = {3'd3, 2'd2, 4'b0100, 1'b0, 1'b1, (n == 0), 1'b0, 2'b00, AW'(0), AW'(0), AW'(0), m_ovf};
        m_p  = p_value_in;
      end
      n_total++;
      if (snap() !== want) $display("FAIL %s seq k=%0d n=%0d got %h exp %h", tag, k, n, snap(), want);
      else n_pass++;
      @(posedge clk); #1;
    end
    for (int h = 0; h <= hold; h++) begin
      data_out_rdy = (h == hold);
      p_value_in   = DW'($urandom);
      x_value      = DW'($urandom);
      y_value      = DW'($urandom);
      @(negedge clk);
      want = {3'd4, 2'd0, 4'd0, 3'd0, 1'b1, 2'b00, AW'(0), AW'(0), AW'(0), m_ovf};
      n_total++;
      if (snap() !== want) $display("FAIL %s end h=%0d got %h exp %h", tag, h, snap(), want);
      else n_pass++;
      n_total++;
      if ({x_value_reg, y_value_reg, p_value} !== {m_xreg, m_yreg, m_p})
        $display("FAIL %s result h=%0d got %h exp %h", tag, h, {x_value_reg, y_value_reg, p_value}, {m_xreg, m_yreg, m_p});
      else n_pass++;
      @(posedge clk); #1;
    end
    data_out_rdy = 1'b0;
    m_ops = m_ops + 16'd1;
    @(negedge clk);
    want = {3'd0, 2'd0, 4'd0, 3'd0, 1'b0, 2'b11, AW'(0), AW'(0), AW'(0), m_ovf};
    n_total++;
    if (snap() !== want) $display("FAIL %s after_accept got %h exp %h", tag, snap(), want);
    else n_pass++;
    n_total++;
    if (op_count !== exp_ops()) $display("FAIL %s op_count got %0d exp %0d", tag, op_count, exp_ops());
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    asyn_reset = 1'b1;
    data_x_vld = 1'b1;
    data_y_vld = 1'b1;
    x_value    = DW'($urandom);
    y_value    = DW'($urandom);
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if (snap() !== 37'd0) $display("FAIL reset_ctrl got %h exp %h", snap(), 37'd0);
    else n_pass++;
    n_total++;
    if ({x_value_reg, y_value_reg, p_value, op_count} !== 22'd0)
      $display("FAIL reset_regs got %h exp %h", {x_value_reg, y_value_reg, p_value, op_count}, 22'd0);
    else n_pass++;
    @(posedge clk); #1;
    asyn_reset = 1'b0;
    data_x_vld = 1'b0;
    data_y_vld = 1'b0;
    model_reset();
    @(negedge clk);
    n_total++;
    if (snap() !== {3'd0, 2'd0, 7'd0, 1'b0, 2'b11, 22'd0})
      $display("FAIL reset_release got %h exp %h", snap(), {3'd0, 2'd0, 7'd0, 1'b0, 2'b11, 22'd0});
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_staggered();
    run_pass(0, 3, 3, 0, "staggered");
  endtask

  task automatic test_same_cycle_n0();
    run_pass(0, 0, 0, 1, "same_cycle_n0");
  endtask

  task automatic test_saturation();
    run_pass(1, 0, 120, 0, "saturate");
    run_pass(0, 2, 2, 0, "post_saturate");
  endtask

  task automatic test_backpressure();
    run_pass(2, 1, 5, 5, "backpressure");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      int cyc;
      cyc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(MAXC + 1, 127)) : int'($urandom_range(0, 12));
      run_pass(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), cyc,
               int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_abort();
    cnt_master = {7'd4, 2'b01};
    data_x_vld = 1'b1;
    data_y_vld = 1'b1;
    x_value    = DW'($urandom);
    y_value    = DW'($urandom);
    @(posedge clk); #1;
    data_x_vld = 1'b0;
    data_y_vld = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if ({STATE, rd_addr} !== {3'd2, 7'd2}) $display("FAIL abort_pre got %h exp %h", {STATE, rd_addr}, {3'd2, 7'd2});
    else n_pass++;
    asyn_reset = 1'b1;
    @(posedge clk); #1;
    asyn_reset = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_total++;
      if ({STATE, data_out_vld, data_x_rdy, data_y_rdy} !== {3'd0, 1'b0, 2'b11})
        $display("FAIL abort_idle i=%0d got %h exp %h", i, {STATE, data_out_vld, data_x_rdy, data_y_rdy}, {3'd0, 1'b0, 2'b11});
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_op_count();
    for (int i = 0; i < 3; i++) begin
      run_pass(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 6)), 0, "op_count");
    end
    @(negedge clk);
    n_total++;
    if (op_count !== exp_ops()) $display("FAIL op_count_total got %0d exp %0d", op_count, exp_ops());
    else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    asyn_reset   = 1'b1;
    cnt_master   = '0;
    x_value      = '0;
    y_value      = '0;
    p_value_in   = '0;
    data_x_vld   = 1'b0;
    data_y_vld   = 1'b0;
    data_out_rdy = 1'b0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_staggered();
    test_same_cycle_n0();
    test_saturation();
    test_backpressure();
    test_random();
    test_abort();
    test_op_count();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
